// File: rtl/peripheral_bfm_memory_wb.sv
// Wishbone B3 slave memory model. Serves classic and registered-feedback
// incrementing bursts (linear/wrap4/8/16) from a byte-addressed word RAM,
// with programmable initial wait states and err termination for
// out-of-range or out-of-sequence beats.
module peripheral_bfm_memory_wb #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned MEM_BASE    = 0,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int unsigned   WORDS = MEM_BYTES / 4;
  localparam int unsigned   IW    = $clog2(WORDS);
  localparam logic [AW-1:0] BASE  = AW'(MEM_BASE);
  localparam logic [AW-1:0] SIZE  = AW'(MEM_BYTES);
  localparam logic [3:0]    WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t        state_q, state_n;
  logic [3:0]    cnt_q, cnt_n;
  logic          rsp_q, rsp_n;     // slave is presenting a response this cycle
  logic [AW-1:0] pred_q, pred_n;   // address expected for the current burst beat
  logic [AW-1:0] pred_nxt;
  logic [DW-1:0] dat_q;
  logic          rd_en;
  logic [AW-1:0] rd_adr;
  logic          go;
  logic [AW-1:0] off;
  logic          in_range, adr_ok, beat;

  logic [DW-1:0] mem [WORDS];

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  // wrapN bursts only advance the low word-index bits, upper bits stay put
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n = a + AW'(4);
      2'b01:   n[3:2] = a[3:2] + 2'd1;
      2'b10:   n[4:2] = a[4:2] + 3'd1;
      default: n[5:2] = a[5:2] + 4'd1;
    endcase
    return n;
  endfunction

  assign off      = wb_adr_i - BASE;
  assign in_range = (wb_adr_i >= BASE) && (off < SIZE);
  // inside a burst the master must follow the slave's prediction
  assign adr_ok   = in_range &&
                    (state_q != S_BURST || wb_adr_i[AW-1:2] == pred_q[AW-1:2]);
  assign beat     = rsp_q & wb_cyc_i & wb_stb_i;
  assign wb_ack_o = beat & adr_ok;
  assign wb_err_o = beat & ~adr_ok;
  assign wb_dat_o = wb_ack_o ? dat_q : '0;
  assign pred_nxt = next_adr(pred_q, wb_bte_i);

  // next-state: wait-state countdown, burst sequencing, read scheduling
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rsp_n   = 1'b0;
    pred_n  = pred_q;
    rd_en   = 1'b0;
    rd_adr  = wb_adr_i;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rsp_q guard keeps a classic master's held stb from re-triggering
        if (wb_cyc_i && wb_stb_i && !rsp_q) begin
          if (WS == 4'd0) go = 1'b1;
          else begin
            cnt_n   = WS;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
        end else if (cnt_q == 4'd1) go = 1'b1;
        else cnt_n = cnt_q - 4'd1;
      end
      S_BURST: begin
        if (!wb_cyc_i) state_n = S_IDLE;
        else if (!wb_stb_i) rsp_n = rsp_q;
        else if (adr_ok && wb_cti_i != 3'b111) begin
          rsp_n  = 1'b1;
          pred_n = pred_nxt;
          rd_en  = 1'b1;
          rd_adr = pred_nxt;
        end else state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (go) begin
      rsp_n   = 1'b1;
      cnt_n   = 4'd0;
      pred_n  = wb_adr_i;
      rd_en   = 1'b1;
      rd_adr  = wb_adr_i;
      state_n = (wb_cti_i == 3'b010) ? S_BURST : S_IDLE;
    end
  end

  // control state registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rsp_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rsp_q   <= rsp_n;
      pred_q  <= pred_n;
    end
  end

  // read data is fetched one cycle ahead of the beat that returns it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) dat_q <= '0;
    else if (rd_en) dat_q <= mem[idx(rd_adr)];
  end

  // byte-lane writes commit only on an acked beat; contents survive reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && wb_ack_o && wb_we_i)
      for (int b = 0; b < DW/8; b++)
        if (wb_sel_i[b]) mem[idx(wb_adr_i)][8*b +: 8] <= wb_dat_i[8*b +: 8];
  end

endmodule

// File: tb/tb_peripheral_bfm_memory_wb.sv
// Directed bench for the Wishbone slave memory model: one instance without
// wait states, one with three, sharing all inputs except cyc.
module tb_peripheral_bfm_memory_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, cyc0 = 1'b0, cyc3 = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;
  bit          use3 = 1'b0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  peripheral_bfm_memory_wb #(.WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat0), .wb_ack_o(ack0),
    .wb_err_o(err0));

  peripheral_bfm_memory_wb #(.WAIT_STATES(3)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat3), .wb_ack_o(ack3),
    .wb_err_o(err3));

  typedef struct {
    bit          d3;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          eack;
    logic [31:0] edat;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] wexp [4] = '{32'd4, 32'd1, 32'd2, 32'd3};
  logic [31:0] wadr [3] = '{32'h0, 32'h4, 32'h8};

  function automatic vec_t mk(bit d3, bit w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] s, bit ea, logic [31:0] ed);
    vec_t v;
    v.d3 = d3; v.we = w; v.adr = a; v.dat = d; v.sel = s; v.eack = ea; v.edat = ed;
    return v;
  endfunction

  function automatic logic c_ack();  return use3 ? ack3 : ack0; endfunction
  function automatic logic c_err();  return use3 ? err3 : err0; endfunction
  function automatic logic [31:0] c_dat(); return use3 ? dat3 : dat0; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_cyc(input logic v);
    if (use3) cyc3 = v; else cyc0 = v;
  endtask

  // returns at the negedge where ack or err is seen; lat counts posedges
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (c_ack() || c_err()) break;
    end
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic ak,
                     output logic er, output logic [31:0] rd);
    @(posedge clk); #1;
    adr = a; dat_w = d; sel = s; we = w; stb = 1'b1; cti = 3'b000; bte = 2'b00;
    set_cyc(1'b1);
    wait_resp(lat);
    ak = c_ack(); er = c_err(); rd = c_dat();
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; set_cyc(1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic ak, er;
    logic [31:0] rd;

    vq.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 1, 32'h0));
    vq.push_back(mk(0, 0, 32'h10,  32'h0,        4'hF, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 1, 32'h10,  32'h0000AA00, 4'h2, 1, 32'h0));
    vq.push_back(mk(0, 0, 32'h10,  32'h0,        4'hF, 1, 32'hDEADAAEF));
    vq.push_back(mk(0, 1, 32'h10,  32'hFFFFFFFF, 4'h0, 1, 32'h0));
    vq.push_back(mk(0, 0, 32'h12,  32'h0,        4'h1, 1, 32'hDEADAAEF));
    vq.push_back(mk(0, 1, 32'h0,   32'd1,        4'hF, 1, 32'h0));
    vq.push_back(mk(0, 1, 32'h4,   32'd2,        4'hF, 1, 32'h0));
    vq.push_back(mk(0, 1, 32'h8,   32'd3,        4'hF, 1, 32'h0));
    vq.push_back(mk(0, 1, 32'hC,   32'd4,        4'hF, 1, 32'h0));
    vq.push_back(mk(0, 1, 32'h3FC, 32'h12345678, 4'hF, 1, 32'h0));
    vq.push_back(mk(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0));
    vq.push_back(mk(0, 0, 32'h3FC, 32'h0,        4'hF, 1, 32'h12345678));
    vq.push_back(mk(0, 0, 32'h400, 32'h0,        4'hF, 0, 32'h0));
    vq.push_back(mk(1, 1, 32'h20,  32'h11111111, 4'hF, 1, 32'h0));
    vq.push_back(mk(1, 1, 32'h24,  32'h22222222, 4'hF, 1, 32'h0));
    vq.push_back(mk(1, 1, 32'h28,  32'hCAFEF00D, 4'hF, 1, 32'h0));
    vq.push_back(mk(1, 0, 32'h28,  32'h0,        4'hF, 1, 32'hCAFEF00D));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_dat", dat0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // classic vector table
    foreach (vq[i]) begin
      use3 = vq[i].d3;
      txn(vq[i].we, vq[i].adr, vq[i].dat, vq[i].sel, lat, ak, er, rd);
      chk($sformatf("v%0d_lat", i), 32'(lat), vq[i].d3 ? 32'd4 : 32'd1);
      chk($sformatf("v%0d_ack", i), 32'(ak), 32'(vq[i].eack));
      chk($sformatf("v%0d_err", i), 32'(er), 32'(!vq[i].eack));
      if (!vq[i].we || !vq[i].eack) chk($sformatf("v%0d_dat", i), rd, vq[i].edat);
    end

    // classic master holding stb: ack must not repeat on the next cycle
    use3 = 1'b0;
    @(posedge clk); #1;
    adr = 32'h10; we = 1'b0; cti = 3'b000; stb = 1'b1; cyc0 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("hold_ack1", 32'(ack0), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("hold_ack2", 32'(ack0), 32'd0);
    cyc0 = 1'b0; stb = 1'b0;

    // wrap4 read burst from 0x0C
    @(posedge clk); #1;
    adr = 32'hC; we = 1'b0; cti = 3'b010; bte = 2'b01; stb = 1'b1; cyc0 = 1'b1;
    wait_resp(lat);
    chk("wrap_lat", 32'(lat), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_ack%0d", k), 32'(ack0), 32'd1);
      chk($sformatf("wrap_dat%0d", k), dat0, wexp[k]);
      @(posedge clk); #1;
      if (k < 3) begin
        adr = wadr[k];
        cti = (k == 2) ? 3'b111 : 3'b010;
      end else begin
        cyc0 = 1'b0; stb = 1'b0;
      end
      @(negedge clk);
    end
    chk("wrap_end_ack", 32'(ack0), 32'd0);

    // burst master jumping off the predicted address gets err
    @(posedge clk); #1;
    adr = 32'h0; cti = 3'b010; bte = 2'b00; stb = 1'b1; cyc0 = 1'b1;
    wait_resp(lat);
    chk("mis_dat0", dat0, 32'd1);
    @(posedge clk); #1 adr = 32'h8;
    @(negedge clk);
    chk("mis_err", 32'(err0), 32'd1);
    chk("mis_ack", 32'(ack0), 32'd0);
    chk("mis_dat", dat0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("mis_after_ack", 32'(ack0), 32'd0);
    chk("mis_after_err", 32'(err0), 32'd0);
    cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;

    // wait-state linear write burst, cyc dropped after two acks
    use3 = 1'b1;
    @(posedge clk); #1;
    adr = 32'h20; dat_w = 32'hA0A0A0A0; sel = 4'hF; we = 1'b1;
    cti = 3'b010; bte = 2'b00; stb = 1'b1; cyc3 = 1'b1;
    wait_resp(lat);
    chk("wb_lat", 32'(lat), 32'd4);
    chk("wb_ack0", 32'(ack3), 32'd1);
    @(posedge clk); #1;
    adr = 32'h24; dat_w = 32'hA1A1A1A1;
    @(negedge clk);
    chk("wb_ack1", 32'(ack3), 32'd1);
    @(posedge clk); #1;
    adr = 32'h28; dat_w = 32'hA2A2A2A2; cyc3 = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("wb_drop_ack", 32'(ack3), 32'd0);
    chk("wb_drop_err", 32'(err3), 32'd0);
    we = 1'b0; cti = 3'b000;
    txn(0, 32'h20, 32'h0, 4'hF, lat, ak, er, rd);
    chk("wb_rd20", rd, 32'hA0A0A0A0);
    txn(0, 32'h24, 32'h0, 4'hF, lat, ak, er, rd);
    chk("wb_rd24", rd, 32'hA1A1A1A1);
    txn(0, 32'h28, 32'h0, 4'hF, lat, ak, er, rd);
    chk("wb_rd28", rd, 32'hCAFEF00D);

    // reset during the wait countdown aborts the cycle
    @(posedge clk); #1;
    adr = 32'h20; we = 1'b0; cti = 3'b000; stb = 1'b1; cyc3 = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rw_ack%0d", c), 32'(ack3), 32'd0);
      chk($sformatf("rw_err%0d", c), 32'(err3), 32'd0);
      chk($sformatf("rw_dat%0d", c), dat3, 32'h0);
    end
    cyc3 = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rw_post_ack", 32'(ack3), 32'd0);
    txn(0, 32'h20, 32'h0, 4'hF, lat, ak, er, rd);
    chk("rw_lat", 32'(lat), 32'd4);
    chk("rw_ack", 32'(ak), 32'd1);
    chk("rw_dat", rd, 32'hA0A0A0A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
